fetch_unit: RTL
===============

# fetch_unit

Parametrised program-counter, instruction-register and data-address unit for the multi-cycle RISC core. It sits between the controller and a variable-latency memory port. It replaces hard-wired PC/IR/address registers and the fixed-timing RAM with a command/ready interface, a req/ack memory handshake, and sign-extended relative branching. An optional return-address stack supports call/return.

## Interface
- ADDR_W, 8, width of PC, data address and memory address
- DATA_W, 16, width of instructions, memory data and datapath values
- OFF_W, 8, width of branch offset, sign-extended to ADDR_W
- RAS_DEPTH, 4, return-address stack entries; used only with the macro

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- start_pc  in  ADDR_W  PC value loaded at reset and by CMD_RESTART
- cmd_valid  in  1  controller command strobe
- cmd_op  in  3  command code, package enum
- cmd_ready  out  1  unit can accept a command this cycle
- offset  in  OFF_W  signed branch/call offset
- addr_in  in  DATA_W  datapath result; low ADDR_W bits feed the data address register
- wdata  in  DATA_W  store data
- mem_req  out  1  memory request, held until acknowledged
- mem_we  out  1  write qualifier for mem_req
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completes the request in this cycle
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1
- ir  out  DATA_W  instruction register
- ir_valid  out  1  one-cycle pulse after IR update
- rdata  out  DATA_W  data-read result register
- rdata_valid  out  1  one-cycle pulse after rdata update
- pc  out  ADDR_W  current PC
- stack_err  out  1  sticky RAS overflow/underflow flag

## Operation
- A command is accepted on any edge where cmd_valid and cmd_ready are both 1. If cmd_ready=0, cmd_valid is ignored and nothing is queued.
- FSM states are S_IDLE and S_MEM. cmd_ready is 1 only in S_IDLE.
- CMD_FETCH: go to S_MEM with mem_addr=pc and mem_we=0. On ack: ir<=mem_rdata, pc<=pc+1, return to S_IDLE.
- CMD_DATA_RD: go to S_MEM with mem_addr=daddr. On ack: rdata<=mem_rdata.
- CMD_DATA_WR: go to S_MEM with mem_addr=daddr, mem_we=1 and mem_wdata=wdata, where wdata is captured at accept.
- CMD_LOAD_ADDR: daddr<=addr_in[ADDR_W-1:0].
- CMD_BRANCH: pc<=pc+sext(offset), modulo 2^ADDR_W. The PC already points past the branch instruction.
- CMD_CALL: push pc, then branch.
- CMD_RET: pc<=pop.
- CMD_RESTART: pc<=start_pc. Does not clear the RAS or stack_err.
- Every command except FETCH/DATA_RD/DATA_WR is single-cycle and stays in S_IDLE.
- Address wrap: pc=2^ADDR_W-1 fetch gives pc=0. Negative offsets wrap the same way.
- Undefined cmd_op values are accepted as no-ops.

## Timing
- Reset values: pc=start_pc (sampled on the reset edge), daddr=0, ir=0, rdata=0, all pulses 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, stack_err=0, RAS empty, state=S_IDLE. cmd_ready=1 in the first cycle after reset.
- Memory commands:
  - Accept at edge E. mem_req, mem_addr, mem_we and mem_wdata are registered and valid from E+1.
  - They are held stable until the edge where mem_ack=1. mem_req drops the following cycle.
  - ir_valid or rdata_valid is high and cmd_ready returns in the cycle after the ack edge.
  - Minimum latency with ack in the first req cycle is 2 cycles from accept to ir_valid.
- mem_ack outside S_MEM is ignored.
- Single-cycle commands: the new pc/daddr is visible the cycle after accept, and cmd_ready stays 1.
- Reset during S_MEM: mem_req=0 next cycle, the pending transaction is abandoned, and there is no valid pulse.

## Configuration
- FETCH_UNIT_RAS_EN defined: a RAS_DEPTH-entry stack.
  - Push when full drops the push, still branches, and sets stack_err.
  - Pop when empty loads start_pc and sets stack_err.
  - stack_err clears only on reset.
- FETCH_UNIT_RAS_EN undefined:
  - CMD_CALL behaves exactly as CMD_BRANCH.
  - CMD_RET behaves as a no-op.
  - stack_err is tied to 0 and there is no stack storage.

## Structure
- Package fetch_pkg holds the cmd_op enum (CMD_FETCH, CMD_BRANCH, CMD_CALL, CMD_RET, CMD_LOAD_ADDR, CMD_DATA_RD, CMD_DATA_WR, CMD_RESTART) and the state enum.
- Sub-module ras_stack, present only under the macro: parameterised depth/width LIFO with push, pop, full, empty and top.

## Test plan
- Reset with start_pc=8'h10, then FETCH, ack in first req cycle, mem_rdata=16'hA5A5 → mem_addr=8'h10, ir=16'hA5A5, pc=8'h11, ir_valid exactly 2 cycles after accept.
- FETCH with mem_ack held low 3 cycles → mem_req/mem_addr stable 4 cycles, cmd_ready=0 throughout, cmd_valid ignored.
- pc=8'h05, BRANCH offset=8'hFA (−6) → pc=8'hFF. Then FETCH → pc=8'h00.
- LOAD_ADDR addr_in=16'h1234, then DATA_WR wdata=16'hBEEF → mem_addr=8'h34, mem_we=1, mem_wdata=16'hBEEF. Then DATA_RD returning 16'hBEEF → rdata=16'hBEEF.
- Macro on, RAS_DEPTH=4: 5 CALLs → 5th branches, stack_err=1. 4 RETs restore pushed PCs in LIFO order; 5th RET → pc=start_pc.
- Reset asserted mid-S_MEM → mem_req=0 next cycle, ir unchanged from reset value 0, no ir_valid.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: command, state and pending-access encodings
// shared by fetch_unit and its bench.
package fetch_pkg;

   typedef enum logic [2:0] {
      CMD_FETCH     = 3'd0,
      CMD_BRANCH    = 3'd1,
      CMD_CALL      = 3'd2,
      CMD_RET       = 3'd3,
      CMD_LOAD_ADDR = 3'd4,
      CMD_DATA_RD   = 3'd5,
      CMD_DATA_WR   = 3'd6,
      CMD_RESTART   = 3'd7
   } cmd_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MEM  = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      K_FETCH = 2'd0,
      K_RD    = 2'd1,
      K_WR    = 2'd2
   } kind_e;

endpackage

// File: rtl/fetch_unit_ras_stack.sv
// ras_stack: small LIFO of return addresses.
// Push when full and pop when empty are dropped.
module ras_stack #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic         full_o,
   output logic         empty_o,
   output logic [W-1:0] top_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CW-1:0] cnt_q;
   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] top_idx;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign top_idx = PW'(cnt_q - 1'b1);
   assign top_o   = mem_q[top_idx];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (push_i && !full_o) begin
         cnt_q <= cnt_q + 1'b1;
      end else if (pop_i && !empty_o) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !full_o) begin
         mem_q[PW'(cnt_q)] <= din_i;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR/data-address unit with req/ack memory port.
// Define FETCH_UNIT_RAS_EN to add the return-address stack.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 16,
   parameter int OFF_W     = 8,
   parameter int RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] start_pc,
   input  logic              cmd_valid,
   input  logic [2:0]        cmd_op,
   output logic              cmd_ready,
   input  logic [OFF_W-1:0]  offset,
   input  logic [DATA_W-1:0] addr_in,
   input  logic [DATA_W-1:0] wdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] ir,
   output logic              ir_valid,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic [ADDR_W-1:0] pc,
   output logic              stack_err
);

   state_e            state_q, state_d;
   kind_e             kind_q, kind_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] daddr_q, daddr_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              irv_q, irv_d;
   logic              rdv_q, rdv_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] maddr_q, maddr_d;
   logic [DATA_W-1:0] mwd_q, mwd_d;
   logic [ADDR_W-1:0] off_ext;
   logic [ADDR_W-1:0] br_tgt;

   assign off_ext = ADDR_W'($signed(offset));
   assign br_tgt  = pc_q + off_ext;

`ifdef FETCH_UNIT_RAS_EN
   logic              ras_push, ras_pop;
   logic              ras_full, ras_empty;
   logic [ADDR_W-1:0] ras_top;
   logic              err_q, err_d;

   ras_stack #(
      .DEPTH (RAS_DEPTH),
      .W     (ADDR_W)
   ) u_ras (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (ras_push),
      .pop_i   (ras_pop),
      .din_i   (pc_q),
      .full_o  (ras_full),
      .empty_o (ras_empty),
      .top_o   (ras_top)
   );

   assign err_d = err_q | (ras_push & ras_full) | (ras_pop & ras_empty);

   always_ff @(posedge clk) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign stack_err = err_q;
`else
   assign stack_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      pc_d    = pc_q;
      daddr_d = daddr_q;
      ir_d    = ir_q;
      rdata_d = rdata_q;
      irv_d   = 1'b0;
      rdv_d   = 1'b0;
      req_d   = req_q;
      we_d    = we_q;
      maddr_d = maddr_q;
      mwd_d   = mwd_q;
`ifdef FETCH_UNIT_RAS_EN
      ras_push = 1'b0;
      ras_pop  = 1'b0;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               case (cmd_e'(cmd_op))
                  CMD_FETCH: begin
                     state_d = S_MEM;
                     kind_d  = K_FETCH;
                     req_d   = 1'b1;
                     we_d    = 1'b0;
                     maddr_d = pc_q;
                  end
                  CMD_DATA_RD: begin
                     state_d = S_MEM;
                     kind_d  = K_RD;
                     req_d   = 1'b1;
                     we_d    = 1'b0;
                     maddr_d = daddr_q;
                  end
                  CMD_DATA_WR: begin
                     state_d = S_MEM;
                     kind_d  = K_WR;
                     req_d   = 1'b1;
                     we_d    = 1'b1;
                     maddr_d = daddr_q;
                     mwd_d   = wdata;
                  end
                  CMD_LOAD_ADDR: daddr_d = addr_in[ADDR_W-1:0];
                  CMD_BRANCH:    pc_d = br_tgt;
                  CMD_CALL: begin
                     pc_d = br_tgt;
`ifdef FETCH_UNIT_RAS_EN
                     ras_push = 1'b1;
`endif
                  end
                  CMD_RET: begin
`ifdef FETCH_UNIT_RAS_EN
                     ras_pop = 1'b1;
                     pc_d    = ras_empty ? start_pc : ras_top;
`endif
                  end
                  CMD_RESTART: pc_d = start_pc;
                  default: ;
               endcase
            end
         end
         S_MEM: begin
            if (mem_ack) begin
               state_d = S_IDLE;
               req_d   = 1'b0;
               we_d    = 1'b0;
               // Writes complete silently; reads raise their own pulse.
               unique case (kind_q)
                  K_FETCH: begin
                     ir_d  = mem_rdata;
                     pc_d  = pc_q + 1'b1;
                     irv_d = 1'b1;
                  end
                  K_RD: begin
                     rdata_d = mem_rdata;
                     rdv_d   = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         kind_q  <= K_FETCH;
         pc_q    <= start_pc;
         daddr_q <= '0;
         ir_q    <= '0;
         rdata_q <= '0;
         irv_q   <= 1'b0;
         rdv_q   <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         maddr_q <= '0;
         mwd_q   <= '0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         pc_q    <= pc_d;
         daddr_q <= daddr_d;
         ir_q    <= ir_d;
         rdata_q <= rdata_d;
         irv_q   <= irv_d;
         rdv_q   <= rdv_d;
         req_q   <= req_d;
         we_q    <= we_d;
         maddr_q <= maddr_d;
         mwd_q   <= mwd_d;
      end
   end

   assign cmd_ready   = (state_q == S_IDLE);
   assign mem_req     = req_q;
   assign mem_we      = we_q;
   assign mem_addr    = maddr_q;
   assign mem_wdata   = mwd_q;
   assign ir          = ir_q;
   assign ir_valid    = irv_q;
   assign rdata       = rdata_q;
   assign rdata_valid = rdv_q;
   assign pc          = pc_q;

endmodule
